// File: rtl/id_pkg.sv
// Shared types and the combinational field packer for the instruction encoder.
// Latency: none (package: types, constants and a pure function).
// Backpressure: n/a.
package id_pkg;

  typedef enum logic [2:0] {
    R      = 3'd0,
    I_OP   = 3'd1,
    I_LOAD = 3'd2,
    S      = 3'd3,
    B      = 3'd4
  } instr_type_e;

  localparam logic [6:0]  OPC_OP     = 7'b0110011;
  localparam logic [6:0]  OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0]  OPC_LOAD   = 7'b0000011;
  localparam logic [6:0]  OPC_STORE  = 7'b0100011;
  localparam logic [6:0]  OPC_BRANCH = 7'b1100011;
  localparam logic [31:0] NOP        = 32'h0000_0013;

  // Only imm[12:0] can ever reach the word; higher bits are the caller's concern.
  function automatic logic [31:0] encode_instr(
    input logic [2:0]  ty,
    input logic [4:0]  rd,
    input logic [4:0]  rs1,
    input logic [4:0]  rs2,
    input logic [2:0]  f3,
    input logic [6:0]  f7,
    input logic [12:0] imm
  );
    logic [31:0] w;
    case (ty)
      R:       w = {f7, rs2, rs1, f3, rd, OPC_OP};
      I_OP:    w = {imm[11:0], rs1, f3, rd, OPC_OPIMM};
      I_LOAD:  w = {imm[11:0], rs1, f3, rd, OPC_LOAD};
      S:       w = {imm[11:5], rs2, rs1, f3, imm[4:0], OPC_STORE};
      B:       w = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], OPC_BRANCH};
      default: w = NOP;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/id_enc_fifo.sv
// Synchronous FIFO holding encoded words between the packer and the consumer.
// Latency: a word pushed in cycle N is at the head in cycle N+1 (empty FIFO).
// Backpressure: push ignored when full, pop ignored when empty; head reads 0 when empty.
module id_enc_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_dat,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign pop_dat = empty ? '0 : mem[rd_ptr];

  // Storage array: written only on an accepted push, no reset needed.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

  // Pointers wrap naturally; the occupancy counter separates full from empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/id_instr_enc.sv
// Packs decoded RV32 fields into instruction words and queues them for the injector.
// Latency: accepted in cycle N, visible on o_instr with o_valid in cycle N+1.
// Backpressure: o_ready drops while the output FIFO is full; optional macro IMM_RANGE_CHECK_EN rejects out-of-range immediates.
module id_instr_enc
  import id_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [2:0]       i_type,
  input  logic [4:0]       i_rd,
  input  logic [4:0]       i_rs1,
  input  logic [4:0]       i_rs2,
  input  logic [2:0]       i_funct3,
  input  logic [6:0]       i_funct7,
  input  logic [31:0]      i_imm,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [31:0]      o_instr,
  output logic [CNT_W-1:0] o_count,
  output logic             o_err
);

  logic        imm_ok;
  logic        push;
  logic        pop;
  logic        full;
  logic        empty;
  logic [31:0] enc_word;

  assign enc_word = encode_instr(i_type, i_rd, i_rs1, i_rs2, i_funct3, i_funct7, i_imm[12:0]);
  assign o_ready  = ~full;
  assign o_valid  = ~empty;
  // A rejected immediate still completes the input handshake, it just never reaches the FIFO.
  assign push     = i_valid & o_ready & imm_ok;
  assign pop      = o_valid & i_ready;

`ifdef IMM_RANGE_CHECK_EN
  logic err_q;

  // Immediates must fit the zero-extended range the decoder would hand back.
  always_comb begin
    imm_ok = 1'b1;
    case (i_type)
      I_OP, I_LOAD, S: imm_ok = (i_imm[31:12] == 20'd0);
      B:               imm_ok = (i_imm[31:13] == 19'd0) && !i_imm[0];
      default:         imm_ok = 1'b1;
    endcase
  end

  // One-cycle error pulse the cycle after a rejected handshake.
  always_ff @(posedge i_clk) begin
    if (i_rst) err_q <= 1'b0;
    else       err_q <= i_valid & o_ready & ~imm_ok;
  end

  assign o_err = err_q;
`else
  logic unused_imm;
  assign imm_ok     = 1'b1;
  assign o_err      = 1'b0;
  assign unused_imm = ^i_imm[31:13];
`endif

  id_enc_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk      (i_clk),
    .rst      (i_rst),
    .push     (push),
    .push_dat (enc_word),
    .pop      (pop),
    .pop_dat  (o_instr),
    .full     (full),
    .empty    (empty)
  );

  // Delivered-word counter, wraps modulo 2^CNT_W.
  always_ff @(posedge i_clk) begin
    if (i_rst)    o_count <= '0;
    else if (pop) o_count <= o_count + CNT_W'(1);
  end

endmodule

// File: tb/tb_id_instr_enc.sv
// Self-checking bench for id_instr_enc: reference model + scoreboard queue + output monitor.
// Latency: n/a (testbench).
// Backpressure: exercises full FIFO, random consumer stalls and mid-transfer reset.
module tb_id_instr_enc;

  logic        i_clk;
  logic        i_rst;
  logic        i_valid;
  logic        o_ready;
  logic [2:0]  i_type;
  logic [4:0]  i_rd;
  logic [4:0]  i_rs1;
  logic [4:0]  i_rs2;
  logic [2:0]  i_funct3;
  logic [6:0]  i_funct7;
  logic [31:0] i_imm;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_instr;
  logic [15:0] o_count;
  logic        o_err;

  int          total;
  int          bad;
  int          cyc;
  bit          rand_rdy;
  logic [31:0] exp_q[$];
  logic [15:0] model_cnt;
  bit          err_set[int];

  id_instr_enc #(.FIFO_DEPTH(4), .CNT_W(16)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_type(i_type), .i_rd(i_rd), .i_rs1(i_rs1), .i_rs2(i_rs2),
    .i_funct3(i_funct3), .i_funct7(i_funct7), .i_imm(i_imm),
    .o_valid(o_valid), .i_ready(i_ready), .o_instr(o_instr),
    .o_count(o_count), .o_err(o_err)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  always @(posedge i_clk) cyc <= cyc + 1;

  // Reference encoding built directly from the field layout with shifts and masks.
  function automatic logic [31:0] ref_enc(int unsigned ty, int unsigned rd, int unsigned rs1,
                                          int unsigned rs2, int unsigned f3, int unsigned f7,
                                          logic [31:0] imm);
    int unsigned w;
    int unsigned im;
    im = imm;
    case (ty)
      0:       w = (f7 << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 32'h33;
      1:       w = ((im & 32'hfff) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 32'h13;
      2:       w = ((im & 32'hfff) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 32'h03;
      3:       w = (((im >> 5) & 32'h7f) << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12)
                   | ((im & 32'h1f) << 7) | 32'h23;
      4:       w = (((im >> 12) & 1) << 31) | (((im >> 5) & 32'h3f) << 25) | (rs2 << 20)
                   | (rs1 << 15) | (f3 << 12) | (((im >> 1) & 32'hf) << 8)
                   | (((im >> 11) & 1) << 7) | 32'h63;
      default: w = 32'h13;
    endcase
    return w;
  endfunction

  function automatic bit ref_legal(int unsigned ty, logic [31:0] imm);
`ifdef IMM_RANGE_CHECK_EN
    if (ty == 1 || ty == 2 || ty == 3) return imm < 32'h1000;
    if (ty == 4) return (imm < 32'h2000) && (imm % 2 == 0);
`endif
    return 1'b1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one input transaction from posedge+#1; returns at posedge+#1 after acceptance.
  task automatic send(input int unsigned ty, input int unsigned rd, input int unsigned rs1,
                      input int unsigned rs2, input int unsigned f3, input int unsigned f7,
                      input logic [31:0] imm, input bit lit_en, input logic [31:0] lit);
    bit acc;
    acc      = 1'b0;
    i_valid  = 1'b1;
    i_type   = 3'(ty);
    i_rd     = 5'(rd);
    i_rs1    = 5'(rs1);
    i_rs2    = 5'(rs2);
    i_funct3 = 3'(f3);
    i_funct7 = 7'(f7);
    i_imm    = imm;
    for (int k = 0; k < 200 && !acc; k++) begin
      @(negedge i_clk);
      if (o_ready) begin
        acc = 1'b1;
        if (ref_legal(ty, imm)) exp_q.push_back(lit_en ? lit : ref_enc(ty, rd, rs1, rs2, f3, f7, imm));
        else err_set[cyc + 1] = 1'b1;
      end
      @(posedge i_clk);
      #1;
    end
    if (!acc) chk("send_accept_timeout", 32'd0, 32'd1);
    i_valid = 1'b0;
    i_imm   = $urandom;
  endtask

  task automatic send_rand();
    int unsigned ty;
    logic [31:0] imm;
    ty  = $urandom_range(0, 7);
    imm = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 8191));
    send(ty, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
         $urandom_range(0, 7), $urandom_range(0, 127), imm, 1'b0, 32'd0);
  endtask

  task automatic wait_empty();
    bit done;
    done = 1'b0;
    for (int k = 0; k < 400 && !done; k++) begin
      @(negedge i_clk);
      if (exp_q.size() == 0 && !o_valid) done = 1'b1;
    end
    if (!done) chk("drain_timeout", 32'(exp_q.size()), 32'd0);
    @(posedge i_clk);
    #1;
  endtask

  // Entered at posedge+#1; checks the state one cycle after reset is sampled.
  task automatic do_reset();
    i_rst   = 1'b1;
    i_valid = 1'b0;
    @(posedge i_clk);
    @(negedge i_clk);
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_ready", 32'(o_ready), 32'd1);
    chk("rst_instr", o_instr, 32'd0);
    chk("rst_count", 32'(o_count), 32'd0);
    chk("rst_err",   32'(o_err), 32'd0);
    exp_q.delete();
    err_set.delete();
    model_cnt = '0;
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
  endtask

  // Output monitor: pops the scoreboard on each output handshake, tracks o_err pulses.
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge i_clk);
      if (!i_rst) begin
        chk("err_pulse", 32'(o_err), 32'(err_set.exists(cyc)));
        if (o_valid && i_ready) begin
          if (exp_q.size() == 0) begin
            chk("spurious_output", o_instr, 32'hxxxxxxxx);
          end else begin
            e = exp_q.pop_front();
            chk("instr", o_instr, e);
            chk("count", 32'(o_count), 32'(model_cnt));
            model_cnt = model_cnt + 16'd1;
          end
        end
      end
    end
  end

  // Random consumer stalls, enabled only during the random phase.
  initial begin
    forever begin
      @(posedge i_clk);
      #1;
      if (rand_rdy) i_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    total = 0; bad = 0; cyc = 0; model_cnt = '0; rand_rdy = 1'b0;
    i_rst = 1'b1; i_valid = 1'b0; i_ready = 1'b1;
    i_type = '0; i_rd = '0; i_rs1 = '0; i_rs2 = '0;
    i_funct3 = '0; i_funct7 = '0; i_imm = '0;
    @(posedge i_clk);
    #1;
    do_reset();

    // addi x1,x0,5: visible the cycle after acceptance
    send(1, 1, 0, 0, 0, 0, 32'd5, 1'b1, 32'h00500093);
    chk("latency_valid", 32'(o_valid), 32'd1);
    chk("latency_instr", o_instr, 32'h00500093);
    wait_empty();
    chk("count_after_addi", 32'(o_count), 32'd1);

    send(3, 0, 1, 2, 2, 0, 32'd8, 1'b1, 32'h0020A423);   // sw x2,8(x1)
    send(4, 0, 1, 2, 0, 0, 32'd16, 1'b1, 32'h00208863);  // beq x1,x2,16
    send(0, 3, 1, 2, 0, 0, 32'd0, 1'b1, 32'h002081B3);   // add x3,x1,x2
    send(5, 7, 9, 11, 3, 99, 32'd123, 1'b1, 32'h00000013);
    send(7, 31, 31, 31, 7, 127, 32'hffffffff, 1'b1, 32'h00000013);
    send(2, 5, 6, 0, 2, 0, 32'd4095, 1'b0, 32'd0);       // lw x5,4095(x6)
    wait_empty();

    // Out-of-range immediates (rejected only when the range check is built in)
    send(1, 1, 0, 0, 0, 0, 32'h00001000, 1'b0, 32'd0);
    send(4, 0, 1, 2, 0, 0, 32'd3, 1'b0, 32'd0);
    send(3, 0, 1, 2, 2, 0, 32'hffff0000, 1'b0, 32'd0);
    send(1, 2, 0, 0, 0, 0, 32'd7, 1'b0, 32'd0);
    wait_empty();

    // Reset with three words queued
    i_ready = 1'b0;
    for (int n = 0; n < 3; n++) send_rand();
    do_reset();
    i_ready = 1'b1;
    send(0, 3, 1, 2, 0, 0, 32'd0, 1'b1, 32'h002081B3);
    wait_empty();

    // Full FIFO: fifth word held until the consumer drains
    do_reset();
    i_ready = 1'b0;
    for (int n = 0; n < 4; n++) send(1, n + 1, n, 0, 0, 0, 32'(n * 3), 1'b0, 32'd0);
    chk("full_ready", 32'(o_ready), 32'd0);
    fork
      send(0, 9, 8, 7, 0, 32, 32'd0, 1'b0, 32'd0);
      begin
        repeat (3) @(posedge i_clk);
        #1;
        chk("held_ready", 32'(o_ready), 32'd0);
        chk("held_head", o_instr, ref_enc(1, 1, 0, 0, 0, 0, 32'd0));
        i_ready = 1'b1;
      end
    join
    wait_empty();
    chk("count_after_five", 32'(o_count), 32'd5);

    // Random traffic with random consumer stalls
    rand_rdy = 1'b1;
    for (int n = 0; n < 300; n++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge i_clk);
        #1;
      end
      send_rand();
    end
    rand_rdy = 1'b0;
    i_ready  = 1'b1;
    wait_empty();
    chk("final_count", 32'(o_count), 32'(model_cnt));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
